// File: rtl/druaga_pkg.sv
// Shared constants and types for the ROM download path.
package druaga_pkg;

   // Board model codes carried in the download stream's model byte
   localparam logic [2:0] DRUAGA   = 3'd0;
   localparam logic [2:0] SUPERPAC = 3'd5;

   // Base addresses of the ROM regions on the download write bus
   localparam logic [16:0] ROM_MAIN_BASE = 17'h00000;
   localparam logic [16:0] ROM_SUB_BASE  = 17'h10000;
   localparam logic [16:0] ROM_WAVE_BASE = 17'h13500;

   // Download sequencing states
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DRAIN,
      ST_DONE
   } dl_state_t;

   // True when the captured model selects the Super Pacman board
   function automatic logic is_superpac(input logic [2:0] model);
      return model == SUPERPAC;
   endfunction

endpackage

// File: rtl/druaga_rom_loader_dl_fifo.sv
// Synchronous FIFO with occupancy count; head word is visible combinationally.
module dl_fifo
   import druaga_pkg::*;
#(
   parameter int unsigned WIDTH      = 25,
   parameter int unsigned DEPTH_LOG2 = 2
) (
   input  logic                  MCLK,
   input  logic                  RESET,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   output logic [WIDTH-1:0]      rd_data,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  empty
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  full;
   logic                  do_wr;
   logic                  do_rd;

   assign full    = (count == COUNT_FULL);
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   // Storage array: written on accepted pushes only, no reset needed
   always_ff @(posedge MCLK) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally modulo DEPTH; count tracks push/pop balance
   always_ff @(posedge MCLK) begin
      if (RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + COUNT_ONE;
            2'b01:   count <= count - COUNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/druaga_rom_loader.sv
// Download stream to ROM write bus: filter, buffer, capture model, paced replay.
module druaga_rom_loader
   import druaga_pkg::*;
#(
   parameter logic [16:0] ROM_TOP    = 17'h1FFFF,
   parameter logic [24:0] MODEL_ADDR = 25'h20000,
   parameter int unsigned GAP        = 3,
   parameter int unsigned DEPTH_LOG2 = 2
) (
   input  logic        MCLK,
   input  logic        RESET,
   input  logic        DL_ACTIVE,
   input  logic        DL_WR,
   input  logic [24:0] DL_ADDR,
   input  logic [7:0]  DL_DATA,
   output logic        DL_WAIT,
   output logic        ROMCL,
   output logic [16:0] ROMAD,
   output logic [7:0]  ROMDT,
   output logic        ROMEN,
   output logic [2:0]  MODEL,
   output logic        DL_DONE,
   output logic [15:0] CHKSUM
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GAP_W-1:0]    GAP_RELOAD = GAP_W'(GAP - 1);
   localparam logic [DEPTH_LOG2:0] WAIT_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH - 1);

   dl_state_t             state;
   dl_state_t             state_nx;
   logic                  act_q;
   logic                  act_rise;
   logic                  act_fall;
   logic                  in_rom;
   logic                  is_model;
   logic                  push;
   logic                  pop;
   logic                  start;
   logic [24:0]           head;
   logic [DEPTH_LOG2:0]   fifo_count;
   logic                  fifo_empty;
   logic [GAP_W-1:0]      gap_cnt;

   assign ROMCL    = MCLK;
   assign DL_DONE  = (state == ST_DONE);

   assign act_rise = DL_ACTIVE && !act_q;
   assign act_fall = !DL_ACTIVE && act_q;
   assign in_rom   = (DL_ADDR <= 25'(ROM_TOP));
   assign is_model = (DL_ADDR == MODEL_ADDR);
   assign push     = DL_WR && in_rom;

   dl_fifo #(
      .WIDTH      (25),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .MCLK    (MCLK),
      .RESET   (RESET),
      .wr_en   (push),
      .wr_data ({DL_ADDR[16:0], DL_DATA}),
      .rd_en   (pop),
      .rd_data (head),
      .count   (fifo_count),
      .empty   (fifo_empty)
   );

   // Registered copy of DL_ACTIVE for edge detection, plus the state register
   always_ff @(posedge MCLK) begin
      if (RESET) begin
         act_q <= 1'b0;
         state <= ST_IDLE;
      end else begin
         act_q <= DL_ACTIVE;
         state <= state_nx;
      end
   end

   // Next-state decode and pop qualification
   always_comb begin
      state_nx = state;
      start    = 1'b0;
      pop      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (act_rise) begin
               start    = 1'b1;
               state_nx = ST_LOAD;
            end
         end
         ST_LOAD: begin
            pop = !fifo_empty && (gap_cnt == '0);
            if (act_fall) begin
               state_nx = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            pop = !fifo_empty && (gap_cnt == '0);
            // A restarted download resumes loading; DONE only once fully drained
            if (act_rise) begin
               state_nx = ST_LOAD;
            end else if (fifo_empty && (gap_cnt == '0)) begin
               state_nx = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // ROM write bus, pacing counter and running checksum
   always_ff @(posedge MCLK) begin
      if (RESET) begin
         ROMEN   <= 1'b0;
         ROMAD   <= '0;
         ROMDT   <= '0;
         CHKSUM  <= '0;
         gap_cnt <= '0;
      end else begin
         ROMEN <= pop;
         if (start) begin
            CHKSUM  <= '0;
            gap_cnt <= '0;
         end else if (pop) begin
            ROMAD   <= head[24:8];
            ROMDT   <= head[7:0];
            CHKSUM  <= CHKSUM + {8'h00, head[7:0]};
            gap_cnt <= GAP_RELOAD;
         end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
         end
      end
   end

   // Model byte capture and registered backpressure flag
   always_ff @(posedge MCLK) begin
      if (RESET) begin
         MODEL   <= '0;
         DL_WAIT <= 1'b0;
      end else begin
         if (DL_WR && is_model) begin
            MODEL <= DL_DATA[2:0];
         end
         DL_WAIT <= (fifo_count >= WAIT_LEVEL);
      end
   end

endmodule

// File: tb/tb_druaga_rom_loader.sv
// Directed self-checking bench for druaga_rom_loader (GAP=3, 4-entry FIFO).
module tb_druaga_rom_loader;

   logic        MCLK = 1'b0;
   logic        RESET;
   logic        DL_ACTIVE;
   logic        DL_WR;
   logic [24:0] DL_ADDR;
   logic [7:0]  DL_DATA;
   logic        DL_WAIT;
   logic        ROMCL;
   logic [16:0] ROMAD;
   logic [7:0]  ROMDT;
   logic        ROMEN;
   logic [2:0]  MODEL;
   logic        DL_DONE;
   logic [15:0] CHKSUM;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [24:0] addr;
      logic [7:0]  data;
      int          exp_en;
      logic [16:0] exp_ad;
      logic [7:0]  exp_dt;
      logic [15:0] exp_chk;
      logic [2:0]  exp_model;
   } vec_t;

   vec_t vecs [8];

   always #10 MCLK = ~MCLK;

   druaga_rom_loader #(
      .ROM_TOP    (17'h1FFFF),
      .MODEL_ADDR (25'h20000),
      .GAP        (3),
      .DEPTH_LOG2 (2)
   ) dut (
      .MCLK      (MCLK),
      .RESET     (RESET),
      .DL_ACTIVE (DL_ACTIVE),
      .DL_WR     (DL_WR),
      .DL_ADDR   (DL_ADDR),
      .DL_DATA   (DL_DATA),
      .DL_WAIT   (DL_WAIT),
      .ROMCL     (ROMCL),
      .ROMAD     (ROMAD),
      .ROMDT     (ROMDT),
      .ROMEN     (ROMEN),
      .MODEL     (MODEL),
      .DL_DONE   (DL_DONE),
      .CHKSUM    (CHKSUM)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge MCLK);
      #1;
   endtask

   initial begin
      int en_cnt;
      int en_off;
      logic [16:0] cap_ad;
      logic [7:0]  cap_dt;
      int wr_i;
      int pulses;
      int last_cyc;
      int wait_first;
      int done_cnt;
      int done_cyc;
      int done_early;

      vecs[0] = '{25'h0000010, 8'hA5, 1, 17'h00010, 8'hA5, 16'h00A5, 3'd0};
      vecs[1] = '{25'h0020000, 8'h05, 0, 17'h00000, 8'h00, 16'h00A5, 3'd5};
      vecs[2] = '{25'h0013500, 8'h3C, 1, 17'h13500, 8'h3C, 16'h00E1, 3'd5};
      vecs[3] = '{25'h0030000, 8'h77, 0, 17'h00000, 8'h00, 16'h00E1, 3'd5};
      vecs[4] = '{25'h001FFFF, 8'hFF, 1, 17'h1FFFF, 8'hFF, 16'h01E0, 3'd5};
      vecs[5] = '{25'h0020001, 8'h99, 0, 17'h00000, 8'h00, 16'h01E0, 3'd5};
      vecs[6] = '{25'h0010000, 8'h80, 1, 17'h10000, 8'h80, 16'h0260, 3'd5};
      vecs[7] = '{25'h0020000, 8'h02, 0, 17'h00000, 8'h00, 16'h0260, 3'd2};

      RESET     = 1'b1;
      DL_ACTIVE = 1'b0;
      DL_WR     = 1'b0;
      DL_ADDR   = '0;
      DL_DATA   = '0;
      repeat (3) tick;
      check("rst_romen",  32'(ROMEN),   0);
      check("rst_wait",   32'(DL_WAIT), 0);
      check("rst_done",   32'(DL_DONE), 0);
      check("rst_model",  32'(MODEL),   0);
      check("rst_chksum", 32'(CHKSUM),  0);
      check("rst_romad",  32'(ROMAD),   0);
      check("rst_romdt",  32'(ROMDT),   0);
      RESET = 1'b0;
      tick;

      DL_ACTIVE = 1'b1;
      repeat (3) tick;

      // Single-byte vectors: one DL_WR each, then watch ROMEN for 7 cycles
      for (int v = 0; v < 8; v++) begin
         DL_WR   = 1'b1;
         DL_ADDR = vecs[v].addr;
         DL_DATA = vecs[v].data;
         en_cnt  = 0;
         en_off  = 0;
         cap_ad  = '0;
         cap_dt  = '0;
         for (int k = 1; k <= 7; k++) begin
            tick;
            DL_WR = 1'b0;
            if (k == 1) begin
               check($sformatf("vec%0d_model", v), 32'(MODEL), 32'(vecs[v].exp_model));
            end
            if (ROMEN) begin
               en_cnt++;
               en_off = k;
               cap_ad = ROMAD;
               cap_dt = ROMDT;
            end
         end
         check($sformatf("vec%0d_en_count", v), 32'(en_cnt), 32'(vecs[v].exp_en));
         if (vecs[v].exp_en != 0) begin
            check($sformatf("vec%0d_latency", v), 32'(en_off), 2);
            check($sformatf("vec%0d_romad", v), 32'(cap_ad), 32'(vecs[v].exp_ad));
            check($sformatf("vec%0d_romdt", v), 32'(cap_dt), 32'(vecs[v].exp_dt));
         end
         check($sformatf("vec%0d_chksum", v), 32'(CHKSUM), 32'(vecs[v].exp_chk));
      end

      // Burst of 8 writes honouring DL_WAIT
      wr_i       = 0;
      pulses     = 0;
      last_cyc   = -1;
      wait_first = -1;
      for (int c = 0; c < 60; c++) begin
         if (ROMEN) begin
            check($sformatf("burst_romad%0d", pulses), 32'(ROMAD), 32'(17'h00100 + 17'(pulses)));
            check($sformatf("burst_romdt%0d", pulses), 32'(ROMDT), 32'(8'h10 + 8'(pulses)));
            if (pulses > 0) begin
               check($sformatf("burst_spacing%0d", pulses), 32'(c - last_cyc), 3);
            end
            last_cyc = c;
            pulses++;
         end
         if (DL_WAIT && wait_first < 0) begin
            wait_first = wr_i;
         end
         if (wr_i < 8 && !DL_WAIT) begin
            DL_WR   = 1'b1;
            DL_ADDR = 25'h0000100 + 25'(wr_i);
            DL_DATA = 8'h10 + 8'(wr_i);
            wr_i++;
         end else begin
            DL_WR = 1'b0;
         end
         tick;
      end
      DL_WR = 1'b0;
      check("burst_pulses",     32'(pulses),     8);
      check("burst_writes",     32'(wr_i),       8);
      check("burst_wait_after", 32'(wait_first), 5);
      check("burst_chksum",     32'(CHKSUM),     32'h02FC);

      // End of download with 3 bytes queued as DL_ACTIVE falls
      pulses   = 0;
      last_cyc = -1;
      done_cnt = 0;
      done_cyc = -1;
      for (int c = 0; c < 30; c++) begin
         if (ROMEN) begin
            check($sformatf("end_romad%0d", pulses), 32'(ROMAD), 32'(17'h00200 + 17'(pulses)));
            last_cyc = c;
            pulses++;
         end
         if (DL_DONE) begin
            done_cnt++;
            done_cyc = c;
         end
         DL_WR   = (c < 3);
         DL_ADDR = 25'h0000200 + 25'(c);
         DL_DATA = 8'h21 + 8'(c);
         if (c == 2) begin
            DL_ACTIVE = 1'b0;
         end
         tick;
      end
      check("end_pulses",   32'(pulses),              3);
      check("end_done_cnt", 32'(done_cnt),            1);
      check("end_done_gap", 32'(done_cyc - last_cyc), 3);
      check("end_chksum",   32'(CHKSUM),              32'h0362);

      // New download, DL_ACTIVE drops then re-rises while draining
      pulses     = 0;
      done_cnt   = 0;
      done_early = 0;
      for (int c = 0; c < 36; c++) begin
         if (ROMEN) begin
            check($sformatf("rer_romad%0d", pulses), 32'(ROMAD), 32'(17'h00300 + 17'(pulses)));
            pulses++;
         end
         if (DL_DONE) begin
            if (c < 26) begin
               done_early++;
            end else begin
               done_cnt++;
            end
         end
         DL_ACTIVE = (c < 4) || (c >= 6 && c < 25);
         DL_WR     = (c >= 2 && c < 5);
         DL_ADDR   = 25'h0000300 + 25'(c - 2);
         DL_DATA   = 8'(c - 1);
         tick;
      end
      DL_WR = 1'b0;
      check("rer_pulses",     32'(pulses),     3);
      check("rer_no_done",    32'(done_early), 0);
      check("rer_final_done", 32'(done_cnt),   1);
      check("rer_chksum",     32'(CHKSUM),     32'h0006);

      // Reset in the middle of a download with 2 bytes queued
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         if (c == 4) begin
            check("mid_romen_before", 32'(ROMEN), 1);
         end
         if (c == 5) begin
            check("mid_model_before", 32'(MODEL), 2);
         end
         DL_ACTIVE = 1'b1;
         DL_WR     = (c >= 2 && c < 5);
         DL_ADDR   = 25'h0000400 + 25'(c);
         DL_DATA   = 8'h40 + 8'(c);
         RESET     = (c == 5);
         tick;
      end
      DL_WR = 1'b0;
      check("mid_rst_romen",  32'(ROMEN),   0);
      check("mid_rst_wait",   32'(DL_WAIT), 0);
      check("mid_rst_model",  32'(MODEL),   0);
      check("mid_rst_chksum", 32'(CHKSUM),  0);
      check("mid_rst_romad",  32'(ROMAD),   0);
      check("mid_rst_romdt",  32'(ROMDT),   0);
      check("mid_rst_done",   32'(DL_DONE), 0);
      RESET = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick;
         if (ROMEN) begin
            pulses++;
         end
      end
      check("mid_no_pops_after", 32'(pulses), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
